if_fetch_queue: RTL and testbench

//  Fetch stage directly downstream of the PC register. Turns pc/ce into synchronous instruction-ROM

---
 rtl/if_fetch_queue_pkg.sv | 14 +
 rtl/if_fetch_queue_fifo.sv | 61 ++++++
 rtl/if_fetch_queue.sv | 91 +++++++++
 tb/tb_if_fetch_queue.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/if_fetch_queue_pkg.sv
// Shared fetch-queue constants: reset level, default depth and bus widths.
package if_fetch_queue_pkg;

  localparam logic RST_ENABLE  = 1'b0;
  localparam int   IFQ_DEPTH   = 4;
  localparam int   INST_ADDR_W = 32;
  localparam int   INST_W      = 32;

  // True once queued entries plus the outstanding ROM response fill every slot.
  function automatic logic credit_exhausted(input int unsigned used, input int unsigned depth);
    return used >= depth;
  endfunction

endpackage

// File: rtl/if_fetch_queue_fifo.sv
// ifq_fifo: DEPTH-entry FIFO of {pc, inst} pairs with clear, occupancy count and combinational head.
module ifq_fifo
  import if_fetch_queue_pkg::*;
#(
  parameter int DEPTH = IFQ_DEPTH,
  parameter int W     = INST_ADDR_W + INST_W
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clear,
  input  logic                       push,
  input  logic                       pop,
  input  logic [W-1:0]               din,
  output logic [W-1:0]               head,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [W-1:0]  mem_reg [DEPTH];
  logic [PW-1:0] wr_ptr_reg;
  logic [PW-1:0] rd_ptr_reg;
  logic [CW-1:0] count_reg;
  logic          do_push;
  logic          do_pop;

  assign do_push = push & ~clear;
  assign do_pop  = pop & (count_reg != '0) & ~clear;

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_entry
      always_ff @(posedge clk) begin
        if (do_push && wr_ptr_reg == PW'(gi))
          mem_reg[gi] <= din;
      end
    end
  endgenerate

  // Pointers are log2(DEPTH) wide, so they wrap modulo DEPTH on their own.
  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE || clear) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      if (do_push && !do_pop)
        count_reg <= count_reg + 1'b1;
      else if (do_pop && !do_push)
        count_reg <= count_reg - 1'b1;
      assert (!(do_push && count_reg == CW'(DEPTH)));
    end
  end

  assign head  = mem_reg[rd_ptr_reg];
  assign count = count_reg;

endmodule

// File: rtl/if_fetch_queue.sv
// Fetch queue: issues ROM reads from pc/ce, pairs responses with their PC and buffers them for decode.
// Optional IFQ_BYPASS_EN forwards a response straight to decode when the queue is empty.
module if_fetch_queue
  import if_fetch_queue_pkg::*;
#(
  parameter int DEPTH  = IFQ_DEPTH,
  parameter int ADDR_W = INST_ADDR_W,
  parameter int DATA_W = INST_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] pc_i,
  input  logic              ce_i,
  input  logic              flush_i,
  output logic              pc_stall_o,
  output logic              rom_ce_o,
  output logic [ADDR_W-1:0] rom_addr_o,
  input  logic [DATA_W-1:0] rom_inst_i,
  output logic              id_valid_o,
  input  logic              id_ready_i,
  output logic [ADDR_W-1:0] id_pc_o,
  output logic [DATA_W-1:0] id_inst_o
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int W  = ADDR_W + DATA_W;

  logic              run;
  logic              inflight_reg;
  logic [ADDR_W-1:0] pc_reg;
  logic [CW-1:0]     count;
  logic [W-1:0]      fifo_head;
  logic [W-1:0]      head_sel;
  logic              fifo_valid;
  logic              resp;
  logic              issue;
  logic              push;
  logic              pop;
  logic              valid_int;

  assign run        = (rst != RST_ENABLE);
  // Credit check ignores a same-cycle pop to keep the stall path short.
  assign pc_stall_o = run & credit_exhausted(int'(count) + int'(inflight_reg), DEPTH);
  assign issue      = run & ce_i & ~pc_stall_o & ~flush_i;
  assign rom_ce_o   = issue;
  assign rom_addr_o = pc_i;
  assign resp       = inflight_reg & ~flush_i;
  assign fifo_valid = (count != '0);
  assign pop        = fifo_valid & id_ready_i;

`ifdef IFQ_BYPASS_EN
  logic bypass;
  assign bypass    = resp & ~fifo_valid;
  assign valid_int = fifo_valid | bypass;
  assign push      = resp & ~(bypass & id_ready_i);
  assign head_sel  = bypass ? {pc_reg, rom_inst_i} : fifo_head;
`else
  assign valid_int = fifo_valid;
  assign push      = resp;
  assign head_sel  = fifo_head;
`endif

  always_ff @(posedge clk) begin
    if (!run) begin
      inflight_reg <= 1'b0;
      pc_reg       <= '0;
    end else begin
      inflight_reg <= issue;
      if (issue) pc_reg <= pc_i;
    end
  end

  ifq_fifo #(
    .DEPTH (DEPTH),
    .W     (W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .clear (flush_i),
    .push  (push),
    .pop   (pop),
    .din   ({pc_reg, rom_inst_i}),
    .head  (fifo_head),
    .count (count)
  );

  assign id_valid_o = run & valid_int;
  assign id_pc_o    = run ? head_sel[W-1:DATA_W] : '0;
  assign id_inst_o  = run ? head_sel[DATA_W-1:0] : '0;

endmodule

// File: tb/tb_if_fetch_queue.sv
// Directed bench for if_fetch_queue: a scoreboard queue of expected {pc, inst} pairs drained by a monitor.
module tb_if_fetch_queue;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] pc_i = '0;
  logic        ce_i = 1'b0;
  logic        flush_i = 1'b0;
  logic        pc_stall_o;
  logic        rom_ce_o;
  logic [31:0] rom_addr_o;
  logic [31:0] rom_inst_i;
  logic        id_valid_o;
  logic        id_ready_i = 1'b0;
  logic [31:0] id_pc_o;
  logic [31:0] id_inst_o;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } pair_t;

  pair_t sb[$];
  int    n_cmp  = 0;
  int    n_fail = 0;

  always #5 clk = ~clk;

  if_fetch_queue dut (
    .clk        (clk),
    .rst        (rst),
    .pc_i       (pc_i),
    .ce_i       (ce_i),
    .flush_i    (flush_i),
    .pc_stall_o (pc_stall_o),
    .rom_ce_o   (rom_ce_o),
    .rom_addr_o (rom_addr_o),
    .rom_inst_i (rom_inst_i),
    .id_valid_o (id_valid_o),
    .id_ready_i (id_ready_i),
    .id_pc_o    (id_pc_o),
    .id_inst_o  (id_inst_o)
  );

  function automatic logic [31:0] rom_word(input logic [31:0] a);
    case (a)
      32'h0:   return 32'h11;
      32'h4:   return 32'h22;
      32'h8:   return 32'h33;
      32'h20:  return 32'hDEAD;
      default: return 32'h1000_0000 | a;
    endcase
  endfunction

  // One-cycle-latency ROM; garbage when not strobed so stray pushes are visible.
  always @(posedge clk)
    rom_inst_i <= rom_ce_o ? rom_word(rom_addr_o) : 32'hBAD0_BAD0;

  task automatic expect_pair(input logic [31:0] pc, input logic [31:0] inst);
    sb.push_back('{pc: pc, inst: inst});
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic ce, input logic [31:0] pc, input logic fl, input logic rdy);
    ce_i = ce; pc_i = pc; flush_i = fl; id_ready_i = rdy;
    #1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rom_ce"},   32'(rom_ce_o),   32'h0);
    check({tag, "_valid"},    32'(id_valid_o), 32'h0);
    check({tag, "_id_pc"},    id_pc_o,         32'h0);
    check({tag, "_id_inst"},  id_inst_o,       32'h0);
    check({tag, "_stall"},    32'(pc_stall_o), 32'h0);
  endtask

  // Monitor: every accepted handshake is popped against the scoreboard.
  initial begin
    pair_t e;
    forever begin
      @(negedge clk);
      if (rst && id_valid_o && id_ready_i && !flush_i) begin
        n_cmp++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_output: got pc=%h inst=%h, expected nothing", id_pc_o, id_inst_o);
        end else begin
          e = sb.pop_front();
          if (id_pc_o !== e.pc || id_inst_o !== e.inst) begin
            n_fail++;
            $display("FAIL scoreboard: got pc=%h inst=%h, expected pc=%h inst=%h",
                     id_pc_o, id_inst_o, e.pc, e.inst);
          end else begin
            $display("txn pc=%h inst=%h ok", id_pc_o, id_inst_o);
          end
        end
      end
    end
  end

  initial begin
    // Reset held with fetch enabled
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 32'h4, 1'b0, 1'b1);
      check_reset_outputs("reset");
      step();
    end
    rst = 1'b1;

    // Streaming, ready held high
    expect_pair(32'h0, 32'h11);
    expect_pair(32'h4, 32'h22);
    expect_pair(32'h8, 32'h33);
    drive(1'b1, 32'h0, 1'b0, 1'b1);
    check("stream_rom_ce", 32'(rom_ce_o), 32'h1);
    check("stream_rom_addr", rom_addr_o, 32'h0);
    step();
    drive(1'b1, 32'h4, 1'b0, 1'b1);
`ifdef IFQ_BYPASS_EN
    check("stream_t1_valid", 32'(id_valid_o), 32'h1);
`else
    check("stream_t1_valid", 32'(id_valid_o), 32'h0);
`endif
    check("stream_stall1", 32'(pc_stall_o), 32'h0);
    step();
    drive(1'b1, 32'h8, 1'b0, 1'b1);
    check("stream_t2_valid", 32'(id_valid_o), 32'h1);
    check("stream_stall2", 32'(pc_stall_o), 32'h0);
    step();
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 32'h0, 1'b0, 1'b1);
      check("stream_stall_idle", 32'(pc_stall_o), 32'h0);
      step();
    end
    check("stream_drained", 32'(sb.size()), 32'h0);

    // Backpressure until credit runs out, then release
    for (int i = 0; i < 5; i++)
      expect_pair(32'h40 + 32'(4 * i), 32'h1000_0040 + 32'(4 * i));
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'h40 + 32'(4 * i), 1'b0, 1'b0);
      check("bp_fill_stall", 32'(pc_stall_o), 32'h0);
      check("bp_fill_rom_ce", 32'(rom_ce_o), 32'h1);
      step();
    end
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'h50, 1'b0, 1'b0);
      check("bp_stall", 32'(pc_stall_o), 32'h1);
      check("bp_no_rom_ce", 32'(rom_ce_o), 32'h0);
      step();
    end
    drive(1'b1, 32'h50, 1'b0, 1'b1);
    check("bp_pop_not_counted", 32'(pc_stall_o), 32'h1);
    step();
    drive(1'b1, 32'h50, 1'b0, 1'b1);
    check("bp_release_stall", 32'(pc_stall_o), 32'h0);
    check("bp_release_rom_ce", 32'(rom_ce_o), 32'h1);
    step();
    for (int i = 0; i < 8; i++) begin
      drive(1'b0, 32'h0, 1'b0, 1'b1);
      step();
    end
    check("bp_idle_valid", 32'(id_valid_o), 32'h0);
    check("bp_drained", 32'(sb.size()), 32'h0);

    // Simultaneous push and pop at count 3, then reset mid-stream
    expect_pair(32'h60, 32'h1000_0060);
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'h60 + 32'(4 * i), 1'b0, 1'b0);
      step();
    end
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    step();
    drive(1'b1, 32'h6C, 1'b0, 1'b0);
    check("pp_count3_stall", 32'(pc_stall_o), 32'h0);
    check("pp_issue", 32'(rom_ce_o), 32'h1);
    step();
    drive(1'b0, 32'h0, 1'b0, 1'b1);
    check("pp_credit_full", 32'(pc_stall_o), 32'h1);
    step();
    drive(1'b1, 32'h70, 1'b0, 1'b0);
    check("pp_count_kept", 32'(pc_stall_o), 32'h0);
    check("pp_issue2", 32'(rom_ce_o), 32'h1);
    step();
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    check("pp_full_again", 32'(pc_stall_o), 32'h1);
    step();
    rst = 1'b0;
    drive(1'b1, 32'h74, 1'b0, 1'b1);
    check_reset_outputs("midrst");
    step();
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 32'h0, 1'b0, 1'b1);
      check("midrst_after_valid", 32'(id_valid_o), 32'h0);
      check("midrst_after_stall", 32'(pc_stall_o), 32'h0);
      step();
    end
    check("midrst_drained", 32'(sb.size()), 32'h0);

    // Flush with three queued entries and 0xDEAD in flight
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, (i == 3) ? 32'h20 : 32'h10 + 32'(4 * i), 1'b0, 1'b0);
      check("fl_fill_rom_ce", 32'(rom_ce_o), 32'h1);
      step();
    end
    expect_pair(32'h100, 32'h1000_0100);
    drive(1'b1, 32'h100, 1'b1, 1'b0);
    check("fl_stall", 32'(pc_stall_o), 32'h1);
    check("fl_rom_ce", 32'(rom_ce_o), 32'h0);
    step();
    drive(1'b1, 32'h100, 1'b0, 1'b1);
    check("fl_next_valid", 32'(id_valid_o), 32'h0);
    check("fl_target_issue", 32'(rom_ce_o), 32'h1);
    check("fl_target_addr", rom_addr_o, 32'h100);
    step();
    drive(1'b0, 32'h0, 1'b0, 1'b1);
`ifdef IFQ_BYPASS_EN
    check("fl_t1_valid", 32'(id_valid_o), 32'h1);
    check("fl_t1_pc", id_pc_o, 32'h100);
`else
    check("fl_t1_valid", 32'(id_valid_o), 32'h0);
`endif
    step();
    drive(1'b0, 32'h0, 1'b0, 1'b1);
`ifndef IFQ_BYPASS_EN
    check("fl_t2_valid", 32'(id_valid_o), 32'h1);
    check("fl_t2_pc", id_pc_o, 32'h100);
`endif
    step();
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 32'h0, 1'b0, 1'b1);
      step();
    end
    check("fl_drained", 32'(sb.size()), 32'h0);

`ifdef IFQ_BYPASS_EN
    // Bypass on an empty queue with decode ready
    expect_pair(32'h8, 32'h33);
    drive(1'b1, 32'h8, 1'b0, 1'b1);
    step();
    drive(1'b0, 32'h0, 1'b0, 1'b1);
    check("byp_valid", 32'(id_valid_o), 32'h1);
    check("byp_pc", id_pc_o, 32'h8);
    check("byp_inst", id_inst_o, 32'h33);
    step();
    drive(1'b0, 32'h0, 1'b0, 1'b1);
    check("byp_not_pushed", 32'(id_valid_o), 32'h0);
    step();
    check("byp_drained", 32'(sb.size()), 32'h0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
